// File: rtl/wb_dpbram_fifo_ctrl.sv
// FIFO controller for a sibling simple dual-port BRAM; 3-cycle word-in to word-out, 1 word/cycle sustained.
// Backpressure: a 2-entry skid buffer absorbs the BRAM read latency; BRAM_FIFO_LEVEL_EN adds the o_level port.
module wb_dpbram_fifo_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wr_valid,
  output logic                  o_wr_ready,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_rd_valid,
  input  logic                  i_rd_ready,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_enA,
  output logic                  o_weA,
  output logic [ADDR_WIDTH-1:0] o_addrA,
  output logic [DATA_WIDTH-1:0] o_dinA,
  output logic                  o_enB,
  output logic [ADDR_WIDTH-1:0] o_addrB,
  input  logic [DATA_WIDTH-1:0] i_doutB
`ifdef BRAM_FIFO_LEVEL_EN
  ,
  output logic [ADDR_WIDTH+1:0] o_level
`endif
);

  localparam logic [ADDR_WIDTH:0] FULL_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   mem_count_q, mem_count_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            obuf_count_q, obuf_count_d;
  logic [DATA_WIDTH-1:0] obuf0_q, obuf0_d;
  logic [DATA_WIDTH-1:0] obuf1_q, obuf1_d;

  logic       wr_ready;
  logic       push;
  logic       pop;
  logic       fetch;
  logic [2:0] committed;
  logic [1:0] obuf_after_pop;

  always_comb begin
    wr_ready = !i_rst && (mem_count_q != FULL_CNT);
    push     = i_wr_valid && wr_ready;
    pop      = (obuf_count_q != 2'd0) && i_rd_ready;

    // Words already owed to the skid buffer once this cycle's pop is taken out.
    committed = {2'b00, inflight_q} + {1'b0, obuf_count_q} - {2'b00, pop};
    fetch     = (mem_count_q != '0) && (committed < 3'd2);

    wr_ptr_d    = wr_ptr_q + {{(ADDR_WIDTH-1){1'b0}}, push};
    rd_ptr_d    = rd_ptr_q + {{(ADDR_WIDTH-1){1'b0}}, fetch};
    mem_count_d = mem_count_q + {{ADDR_WIDTH{1'b0}}, push} - {{ADDR_WIDTH{1'b0}}, fetch};
    inflight_d  = fetch;

    obuf_after_pop = obuf_count_q - {1'b0, pop};
    obuf_count_d   = obuf_after_pop + {1'b0, inflight_q};

    // Entry 0 is the head; the returning BRAM word lands in the first free slot after the pop shift.
    obuf0_d = obuf0_q;
    obuf1_d = obuf1_q;
    if (pop) begin
      obuf0_d = obuf1_q;
    end
    if (inflight_q) begin
      if (obuf_after_pop == 2'd0) begin
        obuf0_d = i_doutB;
      end else begin
        obuf1_d = i_doutB;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      mem_count_q  <= '0;
      inflight_q   <= 1'b0;
      obuf_count_q <= 2'd0;
      obuf0_q      <= '0;
      obuf1_q      <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      mem_count_q  <= mem_count_d;
      inflight_q   <= inflight_d;
      obuf_count_q <= obuf_count_d;
      obuf0_q      <= obuf0_d;
      obuf1_q      <= obuf1_d;
    end
  end

`ifdef BRAM_FIFO_LEVEL_EN
  logic [ADDR_WIDTH+1:0] level_q, level_d;

  always_comb begin
    level_d = {1'b0, mem_count_d} + {{(ADDR_WIDTH+1){1'b0}}, inflight_d}
            + {{ADDR_WIDTH{1'b0}}, obuf_count_d};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      level_q <= '0;
    end else begin
      level_q <= level_d;
    end
  end

  assign o_level = level_q;
`endif

  assign o_wr_ready = wr_ready;
  assign o_enA      = push;
  assign o_weA      = push;
  assign o_addrA    = wr_ptr_q;
  assign o_dinA     = i_wr_data;
  assign o_enB      = fetch;
  assign o_addrB    = rd_ptr_q;
  assign o_rd_valid = (obuf_count_q != 2'd0);
  assign o_rd_data  = obuf0_q;

endmodule

// File: tb/tb_wb_dpbram_fifo_ctrl.sv
// Bench for wb_dpbram_fifo_ctrl with a 4-deep BRAM model and a queue-based FIFO reference model.
module tb_wb_dpbram_fifo_ctrl;

  localparam int DW = 32;
  localparam int AW = 2;
  localparam int CAP = (1 << AW) + 2;

  logic          i_clk;
  logic          i_rst;
  logic          i_wr_valid;
  logic          o_wr_ready;
  logic [DW-1:0] i_wr_data;
  logic          o_rd_valid;
  logic          i_rd_ready;
  logic [DW-1:0] o_rd_data;
  logic          o_enA;
  logic          o_weA;
  logic [AW-1:0] o_addrA;
  logic [DW-1:0] o_dinA;
  logic          o_enB;
  logic [AW-1:0] o_addrB;
  logic [DW-1:0] i_doutB;
`ifdef BRAM_FIFO_LEVEL_EN
  logic [AW+1:0] o_level;
`endif

  wb_dpbram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready), .i_wr_data(i_wr_data),
    .o_rd_valid(o_rd_valid), .i_rd_ready(i_rd_ready), .o_rd_data(o_rd_data),
    .o_enA(o_enA), .o_weA(o_weA), .o_addrA(o_addrA), .o_dinA(o_dinA),
    .o_enB(o_enB), .o_addrB(o_addrB), .i_doutB(i_doutB)
`ifdef BRAM_FIFO_LEVEL_EN
    , .o_level(o_level)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Sibling BRAM: synchronous write on A, registered read on B.
  logic [DW-1:0] bram [1 << AW];
  always @(posedge i_clk) begin
    if (o_enA && o_weA) bram[o_addrA] <= o_dinA;
    if (o_enB) i_doutB <= bram[o_addrB];
  end

  int n_cmp = 0;
  int n_err = 0;
  int mon_cmp = 0;
  int mon_err = 0;

  // Reference model: ordered contents accepted but not yet delivered.
  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] wa = '0;
  logic [AW-1:0] ra = '0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  always @(negedge i_clk) begin
    if (i_rst) begin
      exp_q.delete();
      wa = '0;
      ra = '0;
      prev_stall = 1'b0;
    end else begin
      mon_cmp++;
      if (o_addrA !== wa) begin
        mon_err++; $display("FAIL addrA: got %0d expected %0d", o_addrA, wa);
      end
      mon_cmp++;
      if (o_addrB !== ra) begin
        mon_err++; $display("FAIL addrB: got %0d expected %0d", o_addrB, ra);
      end
`ifdef BRAM_FIFO_LEVEL_EN
      mon_cmp++;
      if (o_level !== (AW+2)'(exp_q.size())) begin
        mon_err++; $display("FAIL level: got %0d expected %0d", o_level, exp_q.size());
      end
`endif
      if (exp_q.size() == 0) begin
        mon_cmp++;
        if (o_rd_valid !== 1'b0 || o_enB !== 1'b0) begin
          mon_err++; $display("FAIL empty: rd_valid=%b enB=%b expected 0/0", o_rd_valid, o_enB);
        end
      end
      if (exp_q.size() >= CAP) begin
        mon_cmp++;
        if (o_wr_ready !== 1'b0) begin
          mon_err++; $display("FAIL full_ready: got %b expected 0 at %0d words", o_wr_ready, exp_q.size());
        end
      end
      if (prev_stall) begin
        mon_cmp++;
        if (o_rd_valid !== 1'b1 || o_rd_data !== prev_data) begin
          mon_err++; $display("FAIL stall_hold: got v=%b d=%h expected v=1 d=%h", o_rd_valid, o_rd_data, prev_data);
        end
      end
      if (o_rd_valid && i_rd_ready) begin
        mon_cmp++;
        if (exp_q.size() == 0) begin
          mon_err++; $display("FAIL pop_order: got %h expected no word", o_rd_data);
        end else begin
          if (o_rd_data !== exp_q[0]) begin
            mon_err++; $display("FAIL pop_order: got %h expected %h", o_rd_data, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
      end
      if (i_wr_valid && o_wr_ready) begin
        exp_q.push_back(i_wr_data);
        wa = wa + 1'b1;
      end
      if (o_enB) ra = ra + 1'b1;
      prev_stall = o_rd_valid && !i_rd_ready;
      prev_data  = o_rd_data;
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_wr_valid = 1'b1; i_wr_data = 32'hDEADBEEF; i_rd_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge i_clk);
      n_cmp++;
      if (o_enA !== 1'b0 || o_wr_ready !== 1'b0 || o_rd_valid !== 1'b0) begin
        n_err++; $display("FAIL reset_hold: enA=%b wr_ready=%b rd_valid=%b expected 0/0/0", o_enA, o_wr_ready, o_rd_valid);
      end
    end
    tick();
    i_rst = 1'b0; i_wr_valid = 1'b0;
    @(negedge i_clk);
    n_cmp++;
    if (o_wr_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_release_ready: got %b expected 1", o_wr_ready);
    end
    n_cmp++;
    if (o_rd_data !== 32'h0 || o_addrA !== 2'd0 || o_addrB !== 2'd0 || o_enB !== 1'b0) begin
      n_err++; $display("FAIL reset_state: data=%h addrA=%0d addrB=%0d enB=%b expected 0", o_rd_data, o_addrA, o_addrB, o_enB);
    end
    tick();
  endtask

  task automatic test_latency();
    i_rd_ready = 1'b0; i_wr_valid = 1'b1; i_wr_data = 32'hA5A5A5A5;
    @(negedge i_clk);
    n_cmp++;
    if (o_wr_ready !== 1'b1) begin
      n_err++; $display("FAIL lat_push: ready got %b expected 1", o_wr_ready);
    end
    tick();
    i_wr_valid = 1'b0;
    @(negedge i_clk);
    n_cmp++;
    if (o_enB !== 1'b1 || o_addrB !== 2'd0 || o_rd_valid !== 1'b0) begin
      n_err++; $display("FAIL lat_fetch: enB=%b addrB=%0d rd_valid=%b expected 1/0/0", o_enB, o_addrB, o_rd_valid);
    end
    tick();
    @(negedge i_clk);
    n_cmp++;
    if (o_rd_valid !== 1'b0) begin
      n_err++; $display("FAIL lat_early: rd_valid got %b expected 0", o_rd_valid);
    end
    tick();
    @(negedge i_clk);
    n_cmp++;
    if (o_rd_valid !== 1'b1 || o_rd_data !== 32'hA5A5A5A5) begin
      n_err++; $display("FAIL lat_out: v=%b d=%h expected 1/a5a5a5a5", o_rd_valid, o_rd_data);
    end
`ifdef BRAM_FIFO_LEVEL_EN
    n_cmp++;
    if (o_level !== 4'd1) begin
      n_err++; $display("FAIL lat_level: got %0d expected 1", o_level);
    end
`endif
    tick();
    i_rd_ready = 1'b1;
    tick();
    i_rd_ready = 1'b0;
  endtask

  task automatic test_fill();
    int acc;
    int got;
    logic [DW-1:0] seen [8];
    acc = 0;
    i_rd_ready = 1'b0;
    for (int v = 1; v <= 7; v++) begin
      i_wr_valid = 1'b1; i_wr_data = DW'(v);
      @(negedge i_clk);
      if (o_wr_ready) acc++;
      tick();
    end
    i_wr_valid = 1'b0;
    tick();
    @(negedge i_clk);
    n_cmp++;
    if (acc != CAP) begin
      n_err++; $display("FAIL fill_accepted: got %0d expected %0d", acc, CAP);
    end
    n_cmp++;
    if (o_wr_ready !== 1'b0) begin
      n_err++; $display("FAIL fill_ready: got %b expected 0", o_wr_ready);
    end
    tick();
    got = 0;
    i_rd_ready = 1'b1;
    for (int c = 0; c < 20 && got < 8; c++) begin
      @(negedge i_clk);
      if (o_rd_valid) begin
        seen[got] = o_rd_data;
        got++;
      end
      tick();
    end
    i_rd_ready = 1'b0;
    n_cmp++;
    if (got != CAP) begin
      n_err++; $display("FAIL fill_drain_count: got %0d expected %0d", got, CAP);
    end
    for (int k = 0; k < CAP && k < got; k++) begin
      n_cmp++;
      if (seen[k] !== DW'(k + 1)) begin
        n_err++; $display("FAIL fill_order[%0d]: got %h expected %h", k, seen[k], k + 1);
      end
    end
  endtask

  task automatic test_streaming();
    int nxt;
    int got;
    bit started;
    bit acc;
    nxt = 0; got = 0; started = 1'b0;
    i_rd_ready = 1'b1;
    for (int c = 0; c < 80 && got < 20; c++) begin
      i_wr_valid = (nxt < 20); i_wr_data = DW'(nxt);
      @(negedge i_clk);
      acc = i_wr_valid && o_wr_ready;
      if (i_wr_valid) begin
        n_cmp++;
        if (!o_wr_ready) begin
          n_err++; $display("FAIL stream_wr_ready: got 0 expected 1 at word %0d", nxt);
        end
      end
      if (o_rd_valid) begin
        n_cmp++;
        if (o_rd_data !== DW'(got)) begin
          n_err++; $display("FAIL stream_data: got %h expected %h", o_rd_data, got);
        end
        got++;
        started = 1'b1;
      end else if (started) begin
        n_cmp++; n_err++;
        $display("FAIL stream_gap: rd_valid got 0 expected 1 after %0d words", got);
      end
      tick();
      if (acc) nxt++;
    end
    i_wr_valid = 1'b0;
    n_cmp++;
    if (got != 20) begin
      n_err++; $display("FAIL stream_count: got %0d expected 20", got);
    end
  endtask

  task automatic test_back_to_back();
    int nacc;
    nacc = 0;
    for (int c = 0; c < 200 && nacc < 30; c++) begin
      i_wr_valid = 1'b1; i_wr_data = $urandom;
      i_rd_ready = c[0];
      @(negedge i_clk);
      if (o_wr_ready) nacc++;
      tick();
    end
    i_wr_valid = 1'b0;
    i_rd_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) tick();
    @(negedge i_clk);
    n_cmp++;
    if (exp_q.size() != 0 || o_rd_valid !== 1'b0) begin
      n_err++; $display("FAIL bp_drain: %0d words left, rd_valid=%b expected 0/0", exp_q.size(), o_rd_valid);
    end
    n_cmp++;
    if (nacc != 30) begin
      n_err++; $display("FAIL bp_accepted: got %0d expected 30", nacc);
    end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      i_wr_valid = ($urandom_range(3, 0) != 0);
      i_wr_data  = $urandom;
      i_rd_ready = ($urandom_range(1, 0) != 0);
      tick();
    end
    i_wr_valid = 1'b0;
    i_rd_ready = 1'b1;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) tick();
    @(negedge i_clk);
    n_cmp++;
    if (exp_q.size() != 0 || o_rd_valid !== 1'b0) begin
      n_err++; $display("FAIL rand_drain: %0d words left, rd_valid=%b expected 0/0", exp_q.size(), o_rd_valid);
    end
    tick();
  endtask

  task automatic test_mid_reset();
    int acc;
    bit seen;
    acc = 0;
    i_rd_ready = 1'b0;
    for (int c = 0; c < 20 && acc < 4; c++) begin
      i_wr_valid = 1'b1; i_wr_data = 32'h1000 + DW'(c);
      @(negedge i_clk);
      if (o_wr_ready) acc++;
      tick();
    end
    i_wr_valid = 1'b0;
    tick(); tick(); tick();
    i_rst = 1'b1;
    @(negedge i_clk);
    n_cmp++;
    if (o_rd_valid !== 1'b0 || o_wr_ready !== 1'b0) begin
      n_err++; $display("FAIL mid_rst_assert: rd_valid=%b wr_ready=%b expected 0/0", o_rd_valid, o_wr_ready);
    end
    tick();
    i_rst = 1'b0;
    @(negedge i_clk);
    n_cmp++;
    if (o_rd_valid !== 1'b0 || o_enB !== 1'b0 || o_wr_ready !== 1'b1) begin
      n_err++; $display("FAIL mid_rst_empty: rd_valid=%b enB=%b wr_ready=%b expected 0/0/1", o_rd_valid, o_enB, o_wr_ready);
    end
`ifdef BRAM_FIFO_LEVEL_EN
    n_cmp++;
    if (o_level !== 4'd0) begin
      n_err++; $display("FAIL mid_rst_level: got %0d expected 0", o_level);
    end
`endif
    tick();
    i_wr_valid = 1'b1; i_wr_data = 32'h55;
    tick();
    i_wr_valid = 1'b0; i_rd_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      @(negedge i_clk);
      if (o_rd_valid) begin
        seen = 1'b1;
        n_cmp++;
        if (o_rd_data !== 32'h55) begin
          n_err++; $display("FAIL mid_rst_first: got %h expected 00000055", o_rd_data);
        end
      end
      tick();
    end
    n_cmp++;
    if (!seen) begin
      n_err++; $display("FAIL mid_rst_timeout: rd_valid got 0 expected 1 within 8 cycles");
    end
    i_rd_ready = 1'b0;
    tick();
  endtask

  initial begin
    i_rst = 1'b1; i_wr_valid = 1'b0; i_wr_data = '0; i_rd_ready = 1'b0;
    test_reset();
    test_latency();
    test_fill();
    test_streaming();
    test_back_to_back();
    test_random();
    test_mid_reset();
    n_cmp = n_cmp + mon_cmp;
    n_err = n_err + mon_err;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wb_dpbram_fifo_ctrl.md
# wb_dpbram_fifo_ctrl

Synchronous FIFO controller that drives the team's simple dual-port BRAM: write port A on the producer side, read port B on the consumer side. It converts a valid/ready write stream into port-A writes. It issues port-B reads, absorbs the BRAM's 1-cycle read latency in a 2-entry output skid buffer, and presents a first-word-fall-through valid/ready read stream at full throughput. It instantiates no memory: the BRAM is a sibling instance wired port-to-port.

## Interface
- DATA_WIDTH, 32, word width; matches the BRAM.
- ADDR_WIDTH, 10, BRAM address width; BRAM depth = 2^ADDR_WIDTH.
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_wr_valid  input  1  producer has a word.
- o_wr_ready  output  1  controller accepts the word this cycle.
- i_wr_data  input  DATA_WIDTH  producer word.
- o_rd_valid  output  1  o_rd_data holds the FIFO head.
- i_rd_ready  input  1  consumer takes the head this cycle.
- o_rd_data  output  DATA_WIDTH  FIFO head, registered.
- o_enA, o_weA  output  1  BRAM port-A enable and write enable.
- o_addrA  output  ADDR_WIDTH  BRAM write address (write pointer).
- o_dinA  output  DATA_WIDTH  BRAM write data (= i_wr_data).
- o_enB  output  1  BRAM port-B read enable (fetch).
- o_addrB  output  ADDR_WIDTH  BRAM read address (read pointer).
- i_doutB  input  DATA_WIDTH  BRAM read data, valid the cycle after o_enB.
- o_level  output  ADDR_WIDTH+2  total occupancy. Present only with BRAM_FIFO_LEVEL_EN.

## Operation
- Write: push = i_wr_valid & o_wr_ready. o_enA = o_weA = push. On push, the word is written at wr_ptr, wr_ptr increments, and mem_count increments.
- o_wr_ready = !i_rst & (mem_count != 2^ADDR_WIDTH). It is combinational from registered state and does not depend on i_rd_ready.
- Fetch: o_enB = fetch = (mem_count != 0) & (inflight + obuf_count - pop < 2), where pop = o_rd_valid & i_rd_ready. On fetch, rd_ptr increments and mem_count decrements. The inflight register is set to fetch.
- Capture: when inflight = 1, i_doutB is written into the skid buffer on that edge. The skid buffer is a 2-entry FIFO; its head drives o_rd_data, and o_rd_valid = (obuf_count != 0).
- mem_count next = mem_count + push - fetch. Simultaneous push and fetch leaves mem_count unchanged.
- Pointers wrap modulo 2^ADDR_WIDTH. mem_count is ADDR_WIDTH+1 bits.
- Total capacity is 2^ADDR_WIDTH + 2 words. Order is strict FIFO.
- No read-during-write hazard can occur. A fetched address was written on an earlier edge. When full, wr_ptr == rd_ptr, but writes are blocked until the fetch edge has passed.

## Timing
- Reset (async assert, sync release): wr_ptr, rd_ptr, mem_count, inflight and obuf_count are 0. o_rd_data = 0, o_rd_valid = 0, o_enB = 0, o_enA = o_weA = 0, o_wr_ready = 0 while i_rst is high and 1 after release. o_addrA = o_addrB = 0. o_level = 0.
- Reset mid-operation discards all contents; BRAM contents are left stale and ignored.
- Latency, empty FIFO: push at edge E0 → fetch during the following cycle → capture at E2 → o_rd_valid high after E2. Word-in to word-out is 3 cycles.
- Throughput: with i_rd_ready held high, one word per cycle is sustained with no bubbles.
- When i_rd_ready deasserts, the skid buffer absorbs the in-flight word and fetch stops. The buffer never overflows.
- o_rd_data and o_rd_valid hold stable while o_rd_valid & !i_rd_ready.
- Empty: o_rd_valid = 0, o_enB = 0, and i_rd_ready is ignored.

## Configuration
- BRAM_FIFO_LEVEL_EN defined: the o_level port exists, registered, equal to mem_count + inflight + obuf_count, and updated every edge.
- BRAM_FIFO_LEVEL_EN undefined: the o_level port and its register are absent. All other behaviour is identical.

## Test plan
- Reset: hold i_rst for 3 cycles with i_wr_valid = 1. Require o_enA = 0, o_wr_ready = 0 and o_rd_valid = 0 throughout. Require o_wr_ready = 1 one cycle after release.
- Latency, ADDR_WIDTH = 2: push 0xA5A5A5A5 into an empty FIFO. Require o_enB = 1 with o_addrB = 0 on the next cycle, o_rd_valid = 1 with o_rd_data = 0xA5A5A5A5 three cycles after the push, and o_level = 1.
- Fill, ADDR_WIDTH = 2, i_rd_ready = 0: push 1..7. Require exactly 6 accepted and o_wr_ready = 0 after the 6th. Then pop to receive 1..6 in order.
- Streaming: i_wr_valid and i_rd_ready held high for 20 words, values 0..19. Require output 0..19 with no gaps once started, and o_addrA/o_addrB wrapping 3→0 correctly.
- Backpressure: toggle i_rd_ready every cycle during streaming. Require no lost or duplicated words, and o_rd_data stable while stalled.
- Mid-operation reset: assert i_rst with 4 words stored. Require an empty FIFO afterwards; the next pushed word 0x55 is the first word read.
